byte_serial_sub: RTL and testbench

BYTE_SERIAL_SUB -- requirements
Module: byte_serial_sub

---
 rtl/byte_serial_sub.sv | 104 ++++++++++
 tb/tb_byte_serial_sub.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_serial_sub.sv
// Byte-serial 32-bit subtractor: one carry-lookahead byte per cycle, IDLE/RUN/DONE FSM.
// Optional signed-overflow output enabled by defining BSS_OVERFLOW_EN.
module byte_serial_sub (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] diff,
    output logic        borrow
`ifdef BSS_OVERFLOW_EN
    ,
    output logic        ovf
`endif
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [31:0] a_r, b_r;
    logic [1:0]  idx;
    logic        carry;
    logic [7:0]  a_byte, b_byte, g, p, sum;
    logic [8:0]  c;

    // Every carry is a flat sum of products of g, p and the incoming carry,
    // so no carry depends on a neighbouring carry.
    function automatic logic [8:0] cla_carries(input logic [7:0] gi, input logic [7:0] pi,
                                               input logic cin);
        logic [8:0] cc;
        logic       term;
        cc[0] = cin;
        for (int i = 0; i < 8; i++) begin
            cc[i+1] = gi[i];
            for (int j = 0; j < i; j++) begin
                term = gi[j];
                for (int k = j + 1; k <= i; k++) term = term & pi[k];
                cc[i+1] = cc[i+1] | term;
            end
            term = cin;
            for (int k = 0; k <= i; k++) term = term & pi[k];
            cc[i+1] = cc[i+1] | term;
        end
        return cc;
    endfunction

    always_comb begin
        a_byte = a_r[{idx, 3'b000} +: 8];
        b_byte = b_r[{idx, 3'b000} +: 8];
        g      = a_byte & ~b_byte;
        p      = a_byte | ~b_byte;
        c      = cla_carries(g, p, carry);
        sum    = a_byte ^ ~b_byte ^ c[7:0];
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            idx    <= '0;
            carry  <= 1'b1;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef BSS_OVERFLOW_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        diff  <= '0;
                        idx   <= '0;
                        carry <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    diff[{idx, 3'b000} +: 8] <= sum;
                    carry <= c[8];
                    idx   <= idx + 2'd1;
                    // Last byte goes straight to DONE; borrow is the inverted final carry.
                    if (idx == 2'd3) begin
                        borrow <= ~c[8];
`ifdef BSS_OVERFLOW_EN
                        ovf    <= c[7] ^ c[8];
`endif
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_byte_serial_sub.sv
// Scoreboard bench for byte_serial_sub: driver queues expected results, monitor checks on done.
module tb_byte_serial_sub;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done, borrow;
    logic [31:0] diff;
`ifdef BSS_OVERFLOW_EN
    logic        ovf;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic        bo;
        logic        ov;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   n_done = 0;
    int   n_issued = 0;

    byte_serial_sub dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow)
`ifdef BSS_OVERFLOW_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no done (diff=%0h)", diff);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_diff", diff, e.d);
                check("sb_borrow", {31'b0, borrow}, {31'b0, e.bo});
`ifdef BSS_OVERFLOW_EN
                check("sb_ovf", {31'b0, ovf}, {31'b0, e.ov});
`endif
            end
        end
    end

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
        exp_t m;
        m.d  = x - y;
        m.bo = (x < y);
        m.ov = (x[31] != y[31]) && (m.d[31] != x[31]);
        return m;
    endfunction

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: got busy stuck high expected idle within 40 cycles");
        end
    endtask

    // Drives one start pulse; returns 1 time unit after the accepting edge with a/b scrambled.
    task automatic start_raw(input logic [31:0] av, input logic [31:0] bv);
        wait_idle();
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] d, input logic bo, input logic ov);
        exp_t e;
        e.d = d; e.bo = bo; e.ov = ov;
        sb.push_back(e);
        n_issued++;
        start_raw(av, bv);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int base;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_diff", diff, 32'd0);
        check("rst_borrow", {31'b0, borrow}, 32'd0);
`ifdef BSS_OVERFLOW_EN
        check("rst_ovf", {31'b0, ovf}, 32'd0);
`endif
        rst_n = 1'b1;

        // 5 - 3: latency and busy length
        issue(32'h5, 32'h3, 32'h2, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("lat_busy_%0d", k), {31'b0, busy}, {31'b0, k <= 4});
            check($sformatf("lat_done_%0d", k), {31'b0, done}, {31'b0, k == 4});
        end
        check("hold_diff", diff, 32'h2);

        issue(32'h0, 32'h1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        issue(32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        issue(32'h1234_5678, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
        issue(32'h0000_00FF, 32'h0000_0100, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // start while busy must be ignored
        wait_idle();
        base = n_done;
        issue(32'd100, 32'd1, 32'd99, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        a = 32'd7;
        b = 32'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        check("ignored_start_dones", n_done, base + 1);
        issue(32'd9, 32'd7, 32'd2, 1'b0, 1'b0);

        // reset during byte 2 aborts the operation
        start_raw(32'h1234_5678, 32'h0101_0101);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_diff", diff, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_borrow", {31'b0, borrow}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        issue(32'h0000_0100, 32'h0000_00FF, 32'h1, 1'b0, 1'b0);

        // start held high: back-to-back ops, exactly one idle cycle between
        wait_idle();
        repeat (3) @(negedge clk);
        a = $urandom;
        b = $urandom;
        start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            sb.push_back(model(a, b));
            n_issued++;
            @(posedge clk);
            #1;
            a = $urandom;
            b = $urandom;
            repeat (5) @(negedge clk);
            if (i < 3 || i % 100 == 0) check("b2b_done", {31'b0, done}, 32'd1);
            @(negedge clk);
            check("b2b_idle", {31'b0, busy}, 32'd0);
            if (i == 999) start = 1'b0;
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        check("done_count", n_done, n_issued);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
